// File: rtl/spi_ctrl.sv
// spi_ctrl: serial master for a bit-serial memory (op bit x2, 8 address bits, 8 data bits for writes, LSB first).
// Optional wait-state watchdog: define SPI_CTRL_TIMEOUT_EN (limit set by parameter TIMEOUT).

module spi_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    input  logic       mosi,
    input  logic       ready,
    input  logic       op_done,
    output logic       cs,
    output logic       miso,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_SEND,
        ST_WAIT_RDY,
        ST_RECV,
        ST_WAIT_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       cs_q, cs_d;
    logic       miso_q, miso_d;
    logic       done_q, done_d;

    // Saturating increment: the counter parks at 15 rather than wrapping to 0.
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_expired;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`endif

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        cs_d    = 1'b1;
        miso_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
        wd_d    = '0;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (newd) begin
                    wr_d    = wr;
                    addr_d  = addr;
                    din_d   = din;
                    cs_d    = 1'b0;
                    miso_d  = wr;
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                cs_d    = 1'b0;
                miso_d  = wr_q;
                cnt_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                cs_d   = 1'b0;
                miso_d = cnt_q[3] ? din_q[cnt_q[2:0]] : addr_q[cnt_q[2:0]];
                cnt_d  = cnt_inc;
                // Leave on the edge that registers the last bit; cs rises one edge later.
                if (cnt_q == (wr_q ? 4'd15 : 4'd7)) begin
                    cnt_d   = 4'd0;
                    state_d = wr_q ? ST_WAIT_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (ready) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RECV;
                end
`ifdef SPI_CTRL_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_RECV: begin
                shift_d = {mosi, shift_q[7:1]};
                cnt_d   = cnt_inc;
                if (cnt_q == 4'd7) begin
                    dout_d  = {mosi, shift_q[7:1]};
                    cnt_d   = 4'd0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (op_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef SPI_CTRL_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 8'd0;
            din_q   <= 8'd0;
            shift_q <= 8'd0;
            dout_q  <= 8'd0;
            cs_q    <= 1'b1;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

    assign cs   = cs_q;
    assign miso = miso_q;
    assign dout = dout_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_ctrl.sv
// tb_spi_ctrl: randomized self-checking bench for spi_ctrl with a bit-serial memory model and a
// spec-level scoreboard (expected bus sequences and read data derived from the frame rules).

module tb_spi_ctrl;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       newd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] din = 8'd0;
    logic       mosi = 1'b0;
    logic       ready = 1'b0;
    logic       op_done = 1'b0;
    logic       cs, miso, busy, done, err;
    logic [7:0] dout;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] bus_mem [256];
    logic       cap [40];
    int         cap_len;
    logic       done_at_s;
    logic [7:0] dout_before, dout_mid;

    spi_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .newd(newd), .wr(wr), .addr(addr), .din(din),
        .mosi(mosi), .ready(ready), .op_done(op_done),
        .cs(cs), .miso(miso), .dout(dout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    // Frame model: op bit twice, address LSB first, then data LSB first for writes.
    function automatic logic [39:0] exp_seq(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [39:0] s;
        s = '0;
        s[0] = w;
        s[1] = w;
        for (int i = 0; i < 8; i++) s[2+i] = a[i];
        if (w) for (int i = 0; i < 8; i++) s[10+i] = d[i];
        return s;
    endfunction

    function automatic int exp_len(input logic w);
        return w ? 18 : 10;
    endfunction

    function automatic logic [39:0] cap_vec();
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < cap_len && i < 40; i++) v[i] = cap[i];
        return v;
    endfunction

    // Request a transaction and record miso on every edge while cs is low (edge S onward).
    task automatic start_and_send(input logic w, input logic [7:0] a, input logic [7:0] d,
                                  input int pulse_at, input logic keep);
        @(negedge clk);
        op_done = 1'b0;
        ready   = 1'b0;
        newd    = 1'b1;
        wr      = w;
        addr    = a;
        din     = d;
        cap_len = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) done_at_s = done;
            if (cs === 1'b1) break;
            cap[cap_len] = miso;
            cap_len++;
            @(negedge clk);
            newd = keep || (c + 1 == pulse_at);
            wr   = 1'($urandom);
            addr = 8'($urandom);
            din  = 8'($urandom);
        end
    endtask

    // Memory side: decode the captured frame, store writes, serve reads, then signal op_done.
    task automatic respond(input int rdy_dly, input int done_dly);
        logic [7:0] ba, bd;
        for (int i = 0; i < 8; i++) begin
            ba[i] = cap[2+i];
            bd[i] = (cap_len > 10 + i) ? cap[10+i] : 1'b0;
        end
        dout_before = dout;
        dout_mid    = dout;
        if (cap[0] === 1'b1) begin
            bus_mem[ba] = bd;
        end else begin
            repeat (rdy_dly) @(negedge clk);
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            mosi  = bus_mem[ba][0];
            for (int i = 1; i < 8; i++) begin
                @(negedge clk);
                mosi = bus_mem[ba][i];
                if (i == 4) dout_mid = dout;
            end
            @(negedge clk);
            mosi = 1'b0;
        end
        repeat (done_dly) @(negedge clk);
        @(negedge clk);
        op_done = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        op_done = 1'b0;
        newd    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (cs !== 1'b1 || miso !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus cs=%b miso=%b busy=%b exp cs=1 miso=0 busy=0", cs, miso, busy);
        end
        checks++;
        if (dout !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_out dout=%h done=%b err=%b exp 00/0/0", dout, done, err);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_write_directed();
        int dc0;
        dc0 = done_cnt;
        start_and_send(1'b1, 8'h05, 8'hA5, -1, 1'b0);
        checks++;
        if (cap_len != exp_len(1'b1)) begin
            failures++;
            $display("FAIL wr_cs_low_cycles got=%0d exp=%0d", cap_len, exp_len(1'b1));
        end
        checks++;
        if (cap_vec() !== exp_seq(1'b1, 8'h05, 8'hA5)) begin
            failures++;
            $display("FAIL wr_miso_seq got=%h exp=%h", cap_vec(), exp_seq(1'b1, 8'h05, 8'hA5));
        end
        checks++;
        if (busy !== 1'b1 || miso !== 1'b0) begin
            failures++;
            $display("FAIL wr_wait_state busy=%b miso=%b exp busy=1 miso=0", busy, miso);
        end
        respond(2, 3);
        ref_mem[8'h05] = 8'hA5;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_complete done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        go_idle();
        checks++;
        if (done !== 1'b0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL wr_done_pulse done=%b pulses=%0d exp done=0 pulses=1", done, done_cnt - dc0);
        end
    endtask

    task automatic test_read_directed();
        int dc0;
        dc0 = done_cnt;
        start_and_send(1'b0, 8'h05, 8'h00, -1, 1'b0);
        checks++;
        if (cap_len != exp_len(1'b0) || cap_vec() !== exp_seq(1'b0, 8'h05, 8'h00)) begin
            failures++;
            $display("FAIL rd_frame len=%0d seq=%h exp len=%0d seq=%h", cap_len, cap_vec(),
                     exp_len(1'b0), exp_seq(1'b0, 8'h05, 8'h00));
        end
        respond(3, 2);
        checks++;
        if (dout_mid !== dout_before) begin
            failures++;
            $display("FAIL rd_dout_early got=%h exp=%h", dout_mid, dout_before);
        end
        checks++;
        if (dout !== ref_mem[8'h05] || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_data dout=%h done=%b busy=%b exp dout=%h done=1 busy=0",
                     dout, done, busy, ref_mem[8'h05]);
        end
        go_idle();
        checks++;
        if (done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL rd_done_pulse pulses=%0d exp=1", done_cnt - dc0);
        end
    endtask

    task automatic test_ignore_newd();
        logic [7:0] a, d;
        int lows, dc0;
        a = 8'($urandom);
        d = 8'($urandom);
        dc0 = done_cnt;
        start_and_send(1'b1, a, d, 4, 1'b0);
        checks++;
        if (cap_len != 18 || cap_vec() !== exp_seq(1'b1, a, d)) begin
            failures++;
            $display("FAIL ign_frame len=%0d seq=%h exp len=18 seq=%h", cap_len, cap_vec(), exp_seq(1'b1, a, d));
        end
        respond(0, 1);
        ref_mem[a] = d;
        go_idle();
        lows = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (cs !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0 || done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL ign_extra_txn active_cycles=%0d pulses=%0d exp 0 and 1", lows, done_cnt - dc0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, d;
        int dc0;
        @(negedge clk);
        newd = 1'b1;
        wr   = 1'b1;
        addr = 8'($urandom);
        din  = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        newd = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cs !== 1'b1 || busy !== 1'b0 || miso !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_async cs=%b busy=%b miso=%b dout=%h exp 1/0/0/00", cs, busy, miso, dout);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        a = 8'($urandom_range(0, 7));
        d = 8'($urandom);
        dc0 = done_cnt;
        start_and_send(1'b1, a, d, -1, 1'b0);
        checks++;
        if (cap_len != 18 || cap_vec() !== exp_seq(1'b1, a, d)) begin
            failures++;
            $display("FAIL rstmid_clean len=%0d seq=%h exp len=18 seq=%h", cap_len, cap_vec(), exp_seq(1'b1, a, d));
        end
        respond(1, 1);
        ref_mem[a] = d;
        go_idle();
        checks++;
        if (done_cnt != dc0 + 1) begin
            failures++;
            $display("FAIL rstmid_done pulses=%0d exp=1", done_cnt - dc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1, d1, a2, d2;
        int dc0;
        a1 = 8'($urandom_range(0, 7));
        d1 = 8'($urandom);
        a2 = 8'($urandom_range(0, 7));
        d2 = 8'($urandom);
        dc0 = done_cnt;
        start_and_send(1'b1, a1, d1, -1, 1'b1);
        respond(1, 2);
        ref_mem[a1] = d1;
        checks++;
        if (done !== 1'b1 || cs !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_done done=%b cs=%b exp done=1 cs=1", done, cs);
        end
        start_and_send(1'b1, a2, d2, -1, 1'b0);
        checks++;
        if (done_at_s !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overlap done_at_accept=%b exp=0", done_at_s);
        end
        checks++;
        if (cap_len != 18 || cap_vec() !== exp_seq(1'b1, a2, d2)) begin
            failures++;
            $display("FAIL b2b_second len=%0d seq=%h exp len=18 seq=%h", cap_len, cap_vec(), exp_seq(1'b1, a2, d2));
        end
        respond(0, 0);
        ref_mem[a2] = d2;
        go_idle();
        checks++;
        if (done_cnt != dc0 + 2) begin
            failures++;
            $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt - dc0);
        end
    endtask

    task automatic test_random();
        logic       w;
        logic [7:0] a, d;
        int dc0;
        for (int n = 0; n < 16; n++) begin
            w = 1'($urandom);
            a = 8'($urandom_range(0, 7));
            d = 8'($urandom);
            dc0 = done_cnt;
            start_and_send(w, a, d, -1, 1'b0);
            checks++;
            if (cap_len != exp_len(w) || cap_vec() !== exp_seq(w, a, d)) begin
                failures++;
                $display("FAIL rnd%0d_frame wr=%b len=%0d seq=%h exp len=%0d seq=%h", n, w, cap_len,
                         cap_vec(), exp_len(w), exp_seq(w, a, d));
            end
            respond($urandom_range(0, 5), $urandom_range(0, 5));
            if (w) begin
                ref_mem[a] = d;
            end else begin
                checks++;
                if (dout !== ref_mem[a]) begin
                    failures++;
                    $display("FAIL rnd%0d_read addr=%h dout=%h exp=%h", n, a, dout, ref_mem[a]);
                end
            end
            go_idle();
            checks++;
            if (done_cnt != dc0 + 1 || busy !== 1'b0 || cs !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_end pulses=%0d busy=%b cs=%b exp 1/0/1", n, done_cnt - dc0, busy, cs);
            end
        end
    endtask

`ifdef SPI_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int seen, dc0;
        dc0 = done_cnt;
        start_and_send(1'b0, 8'($urandom_range(0, 7)), 8'h00, -1, 1'b0);
        dout_before = dout;
        seen = -1;
        for (int c = 1; c < TIMEOUT + 20; c++) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) begin
                seen = c;
                break;
            end
        end
        // WAIT_RDY is entered on the edge registering the last address bit, one edge before cs rises.
        checks++;
        if (seen != TIMEOUT - 1) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d edges after cs rise", seen, TIMEOUT - 1);
        end
        checks++;
        if (busy !== 1'b0 || cs !== 1'b1 || dout !== dout_before || done_cnt != dc0) begin
            failures++;
            $display("FAIL timeout_state busy=%b cs=%b dout=%h pulses=%0d exp 0/1/%h/0",
                     busy, cs, dout, done_cnt - dc0, dout_before);
        end
        go_idle();
        checks++;
        if (err !== 1'b0 || err_cnt != 1) begin
            failures++;
            $display("FAIL timeout_pulse err=%b pulses=%0d exp err=0 pulses=1", err, err_cnt);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [7:0] a;
        a = 8'($urandom_range(0, 7));
        start_and_send(1'b0, a, 8'h00, -1, 1'b0);
        respond(3 * TIMEOUT, 0);
        checks++;
        if (dout !== ref_mem[a] || done !== 1'b1) begin
            failures++;
            $display("FAIL long_wait dout=%h done=%b exp dout=%h done=1", dout, done, ref_mem[a]);
        end
        go_idle();
        checks++;
        if (err_cnt != 0) begin
            failures++;
            $display("FAIL err_pulses got=%0d exp=0", err_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            bus_mem[i] = ref_mem[i];
        end
        test_reset();
        test_write_directed();
        test_read_directed();
        test_ignore_newd();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SPI_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog time=%0t exp completion before 500000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
